// File: rtl/nco_iq_pkg.sv
// nco_pkg: quadrant type, quarter-wave table generator and LFSR constants shared by nco_iq.
package nco_pkg;
    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Sample at bin centres so the folded table is symmetric and never hits zero or +/-full scale overflow
    function automatic int quarter_sin(int k, int lw, int dw);
        real amp;
        real th;
        amp = real'((1 << (dw - 1)) - 1);
        th  = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(4 << lw);
        return int'(amp * $sin(th));
    endfunction
endpackage

// File: rtl/nco_iq_if.sv
// nco_iq_if: valid/ready stream carrying the I (cos) and Q (sin) oscillator samples.
interface nco_iq_if #(
    parameter int DW = 16
) ();
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] sample_inphase_osc;
    logic signed [DW-1:0] sample_quadrature_osc;
    modport master (output out_valid, sample_inphase_osc, sample_quadrature_osc, input out_ready);
    modport slave  (input out_valid, sample_inphase_osc, sample_quadrature_osc, output out_ready);
endinterface

// File: rtl/nco_quarter_rom.sv
// nco_quarter_rom: registered dual-read quarter-wave sine magnitude table, N = 2^LW entries.
module nco_quarter_rom
    import nco_pkg::*;
#(
    parameter int LW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [LW-1:0] i_addr_a,
    input  logic [LW-1:0] i_addr_b,
    output logic [DW-2:0] o_data_a,
    output logic [DW-2:0] o_data_b
);
    logic [DW-2:0] w_tab [2**LW];
    for (genvar k = 0; k < 2**LW; k++) begin : g_tab
        assign w_tab[k] = (DW-1)'(quarter_sin(k, LW, DW));
    end
    always_ff @(posedge clk) begin
        if (i_en) begin
            o_data_a <= w_tab[i_addr_a];
            o_data_b <= w_tab[i_addr_b];
        end
    end
endmodule

// File: rtl/nco_iq.sv
// nco_iq: quadrature NCO, pipeline S0 phase -> S1 fold -> S2 table -> S3 sign/output, valid/ready out.
// Define NCO_DITHER_EN to add LFSR dither to the phase bits below the table address.
module nco_iq
    import nco_pkg::*;
#(
    parameter int DW = 16,
    parameter int PW = 32,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [PW-1:0] phase_inc,
    input  logic          inc_load,
    input  logic          phase_clr,
    nco_iq_if.master      o_osc
);
    logic                 w_adv;
    logic                 w_enter;
    logic [PW-1:0]        r_acc;
    logic [PW-1:0]        r_inc;
    logic [LW+1:0]        w_ph;
    logic [LW+1:0]        r_ph0;
    logic [3:0]           r_v;
    quadrant_t            r_q1;
    quadrant_t            r_q2;
    logic [LW-1:0]        r_a1;
    logic [DW-2:0]        w_t_a;
    logic [DW-2:0]        w_t_na;
    logic signed [DW-1:0] w_s_mag;
    logic signed [DW-1:0] w_c_mag;
    logic                 w_s_neg;
    logic                 w_c_neg;
    logic signed [DW-1:0] r_i;
    logic signed [DW-1:0] r_q;

    assign w_adv   = !r_v[3] || o_osc.out_ready;
    assign w_enter = en && w_adv;
`ifdef NCO_DITHER_EN
    localparam int DB = (PW - LW - 2) < 16 ? PW - LW - 2 : 16;
    logic [15:0] r_lfsr;
    // Dither only perturbs the table lookup; the accumulator stays exact
    assign w_ph = (LW+2)'((r_acc + PW'(r_lfsr[DB-1:0])) >> (PW - LW - 2));
    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= LFSR_SEED;
        else if (w_enter)
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0);
    end
`else
    assign w_ph = r_acc[PW-1 -: LW+2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_inc <= '0;
            r_v   <= '0;
            r_i   <= '0;
            r_q   <= '0;
        end else begin
            if (inc_load)
                r_inc <= phase_inc;
            if (phase_clr)
                r_acc <= '0;
            else if (w_enter)
                r_acc <= r_acc + r_inc;
            if (w_adv)
                r_v <= {r_v[2:0], en};
            if (w_adv && r_v[2]) begin
                r_i <= w_c_neg ? -w_c_mag : w_c_mag;
                r_q <= w_s_neg ? -w_s_mag : w_s_mag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_ph0 <= w_ph;
            r_q1  <= quadrant_t'(r_ph0[LW+1 -: 2]);
            r_a1  <= r_ph0[LW-1:0];
            r_q2  <= r_q1;
        end
    end

    nco_quarter_rom #(.LW(LW), .DW(DW)) u_rom (
        .clk      (clk),
        .i_en     (w_adv),
        .i_addr_a (r_a1),
        .i_addr_b (~r_a1),
        .o_data_a (w_t_a),
        .o_data_b (w_t_na)
    );

    // sin: +T[a], +T[~a], -T[a], -T[~a]; cos: +T[~a], -T[a], -T[~a], +T[a]
    always_comb begin
        w_s_mag = (r_q2 == Q0 || r_q2 == Q2) ? {1'b0, w_t_a} : {1'b0, w_t_na};
        w_c_mag = (r_q2 == Q0 || r_q2 == Q2) ? {1'b0, w_t_na} : {1'b0, w_t_a};
        w_s_neg = r_q2 == Q2 || r_q2 == Q3;
        w_c_neg = r_q2 == Q1 || r_q2 == Q2;
    end

    assign o_osc.out_valid             = r_v[3];
    assign o_osc.sample_inphase_osc    = r_i;
    assign o_osc.sample_quadrature_osc = r_q;
endmodule

// File: tb/tb_nco_iq.sv
// tb_nco_iq: scoreboard bench for nco_iq; entered phases are queued and checked against a real-valued model.
module tb_nco_iq;
    localparam int    DW  = 16;
    localparam int    PW  = 32;
    localparam int    LW  = 8;
    localparam longint AMP = 32767;
    localparam real   PI  = 3.14159265358979323846;

    logic          clk = 0;
    logic          reset = 1;
    logic          en = 0;
    logic          inc_load = 0;
    logic          phase_clr = 0;
    logic [PW-1:0] phase_inc = '0;

    nco_iq_if #(.DW(DW)) osc ();

    nco_iq #(.DW(DW), .PW(PW), .LW(LW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .phase_inc (phase_inc),
        .inc_load  (inc_load),
        .phase_clr (phase_clr),
        .o_osc     (osc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(string tag, longint got, longint exp, longint tol = 0);
        checks++;
        if ((got > exp ? got - exp : exp - got) > tol) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    // Reference model: accumulator, valid pipeline, queue of entered phases
    logic [PW-1:0] m_acc;
    logic [PW-1:0] m_inc;
    logic [3:0]    m_v;
    bit            m_adv;
    logic [PW-1:0] sb_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_acc = '0;
            m_inc = '0;
            m_v   = '0;
            sb_q.delete();
        end else begin
            m_adv = !m_v[3] || osc.out_ready;
            if (m_adv) begin
                m_v = {m_v[2:0], en};
                if (en)
                    sb_q.push_back(m_acc);
            end
            if (phase_clr)
                m_acc = '0;
            else if (m_adv && en)
                m_acc = m_acc + m_inc;
            if (inc_load)
                m_inc = phase_inc;
        end
    end

    typedef struct {longint i; longint q;} iq_t;
    iq_t           obs_q[$];
    bit            prev_stall = 0;
    longint        prev_i;
    longint        prev_q;
    logic [PW-1:0] mon_ph;
    real           mon_th;
    longint        mon_i;
    longint        mon_q;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            check("valid", osc.out_valid, m_v[3]);
            if (prev_stall && osc.out_valid) begin
                check("hold_i", osc.sample_inphase_osc, prev_i);
                check("hold_q", osc.sample_quadrature_osc, prev_q);
            end
            if (osc.out_valid && osc.out_ready) begin
                mon_i = osc.sample_inphase_osc;
                mon_q = osc.sample_quadrature_osc;
                if (sb_q.size() == 0) begin
                    check("sb_size", sb_q.size(), 1);
                end else begin
                    mon_ph = sb_q.pop_front();
                    mon_th = 2.0 * PI * (real'(mon_ph >> (PW - LW - 2)) + 0.5) / real'(4 << LW);
                    check("I", mon_i, longint'(real'(AMP) * $cos(mon_th)), 1);
                    check("Q", mon_q, longint'(real'(AMP) * $sin(mon_th)), 1);
                    check("mag", mon_i * mon_i + mon_q * mon_q, AMP * AMP, AMP * AMP / 1000);
                end
                obs_q.push_back('{mon_i, mon_q});
            end
            prev_stall = osc.out_valid && !osc.out_ready;
            prev_i = osc.sample_inphase_osc;
            prev_q = osc.sample_quadrature_osc;
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_obs(int n);
        int b = 0;
        while (obs_q.size() < n && b < 200) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (obs_q.size() < n)
            check("obs_timeout", obs_q.size(), n);
    endtask

    task automatic load_inc(logic [PW-1:0] v);
        phase_inc = v;
        inc_load = 1;
        step();
        inc_load = 0;
    endtask

    task automatic check_seq(string tag, int n);
        longint seq_i[4] = '{32767, -101, -32767, 101};
        longint seq_q[4] = '{101, 32767, -101, -32767};
        for (int k = 0; k < n && k < obs_q.size(); k++) begin
            check({tag, "_i"}, obs_q[k].i, seq_i[k % 4]);
            check({tag, "_q"}, obs_q[k].q, seq_q[k % 4]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

    initial begin
        int n0;
        int found;
        osc.out_ready = 1;
        step(2);
        reset = 0;
        @(negedge clk);
        check("rst_valid", osc.out_valid, 0);
        check("rst_i", osc.sample_inphase_osc, 0);
        check("rst_q", osc.sample_quadrature_osc, 0);
        step();
        // Quarter-turn tone, then first-sample latency
        load_inc(32'h4000_0000);
        en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_early", osc.out_valid, 0);
        @(negedge clk);
        check("lat", osc.out_valid, 1);
        wait_obs(6);
        // Backpressure mid-stream
        step();
        osc.out_ready = 0;
        step(5);
        osc.out_ready = 1;
        wait_obs(14);
        check_seq("seq", 14);
        // phase_clr mid-stream on an irregular tone
        step();
        load_inc(32'h1234_5678);
        step(6);
        phase_clr = 1;
        step();
        phase_clr = 0;
        n0 = obs_q.size();
        wait_obs(n0 + 6);
        found = 0;
        for (int k = n0; k < n0 + 6 && k < obs_q.size(); k++)
            if (obs_q[k].i == 32767 && obs_q[k].q == 101)
                found = 1;
        check("clr_phase0", found, 1);
        // DC with zero increment, then drain on en=0
        step();
        load_inc(32'h0);
        step(10);
        check("dc_i", obs_q[obs_q.size()-1].i, obs_q[obs_q.size()-2].i);
        check("dc_q", obs_q[obs_q.size()-1].q, obs_q[obs_q.size()-2].q);
        en = 0;
        @(negedge clk);
        #1;
        n0 = obs_q.size();
        step(8);
        check("drain_cnt", obs_q.size() - n0, 3);
        check("drain_valid", osc.out_valid, 0);
        // Reset while stalled, then restart
        load_inc(32'h4000_0000);
        en = 1;
        step(6);
        osc.out_ready = 0;
        step(3);
        reset = 1;
        en = 0;
        step();
        reset = 0;
        osc.out_ready = 1;
        @(negedge clk);
        check("rst2_valid", osc.out_valid, 0);
        check("rst2_i", osc.sample_inphase_osc, 0);
        check("rst2_q", osc.sample_quadrature_osc, 0);
        obs_q.delete();
        step();
        load_inc(32'h4000_0000);
        en = 1;
        wait_obs(8);
        check_seq("restart", 8);
        // Random tuning words with random en/ready/phase_clr
        for (int t = 0; t < 20; t++) begin
            step();
            load_inc($urandom);
            repeat (300) begin
                osc.out_ready = $urandom_range(0, 3) != 0;
                en = $urandom_range(0, 7) != 0;
                phase_clr = $urandom_range(0, 63) == 0;
                step();
            end
            phase_clr = 0;
        end
        en = 0;
        osc.out_ready = 1;
        step(10);
        check("sb_left", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
